// File: rtl/sonar_pkg.sv
// Shared constants for the sonar receive chain and the echo detector state type.
package sonar_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int TIME_WIDTH = 24;
    localparam int MIDSCALE   = 32768;

    // ARMED: waiting for a crossing; CONFIRM: counting a run; DETECTED: echo reported.
    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CONFIRM  = 2'd1,
        DETECTED = 2'd2
    } det_state_t;

endpackage

// File: rtl/echo_detector_envelope_filter.sv
// Envelope filter: rectifies offset-binary samples (stage 1) and smooths them
// with a 2^AVG_LOG2 moving average (stage 2). Each stage advances only on valid.
module envelope_filter #(
    parameter int DATA_WIDTH = sonar_pkg::DATA_WIDTH,
    parameter int TIME_WIDTH = sonar_pkg::TIME_WIDTH,
    parameter int MIDSCALE   = sonar_pkg::MIDSCALE,
    parameter int AVG_LOG2   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic [TIME_WIDTH-1:0] ts_i,
    output logic [DATA_WIDTH-1:0] envelope_o,
    output logic [TIME_WIDTH-1:0] ts_o,
    output logic                  valid_o
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_WIDTH + AVG_LOG2;

    logic signed [DATA_WIDTH:0]   diff;
    logic        [DATA_WIDTH-1:0] mag_d;
    logic        [DATA_WIDTH-1:0] mag_q;
    logic        [TIME_WIDTH-1:0] ts1_q;
    logic                         v1_q;

    logic [DATA_WIDTH-1:0] hist_q [DEPTH];
    logic [AVG_LOG2-1:0]   wptr_q;
    logic [SUM_W-1:0]      sum_q;
    logic [SUM_W-1:0]      sum_d;
    logic [DATA_WIDTH-1:0] env_q;
    logic [TIME_WIDTH-1:0] ts2_q;
    logic                  v2_q;

    // Signed distance from midscale; the most negative code (sample 0) has
    // magnitude 2^(DATA_WIDTH-1), which still fits the unsigned result.
    always_comb begin
        diff  = $signed({1'b0, sample_i}) - $signed((DATA_WIDTH+1)'(MIDSCALE));
        mag_d = diff[DATA_WIDTH-1:0];
        if (diff[DATA_WIDTH]) begin
            mag_d = DATA_WIDTH'(-diff);
        end
    end

    // Stage 1: register the magnitude and the timestamp that goes with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q <= '0;
            ts1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                mag_q <= mag_d;
                ts1_q <= ts_i;
            end
        end
    end

    // Running sum: add the newest magnitude, drop the one it overwrites.
    always_comb begin
        sum_d = sum_q + SUM_W'(mag_q) - SUM_W'(hist_q[wptr_q]);
    end

    // Stage 2: update the circular history, the sum and the envelope.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wptr_q <= '0;
            sum_q  <= '0;
            env_q  <= '0;
            ts2_q  <= '0;
            v2_q   <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                hist_q[wptr_q] <= mag_q;
                wptr_q         <= wptr_q + AVG_LOG2'(1);
                sum_q          <= sum_d;
                env_q          <= DATA_WIDTH'(sum_d >> AVG_LOG2);
                ts2_q          <= ts1_q;
            end
        end
    end

    assign envelope_o = env_q;
    assign ts_o       = ts2_q;
    assign valid_o    = v2_q;

endmodule

// File: rtl/echo_detector.sv
// Echo detector: envelope filter followed by a blanking-aware run-length
// confirmation FSM that reports the first echo of each burst with its timestamp.
//
// Handshake: sample_valid_in qualifies sample_in/time_since_emission for exactly
// the cycle it is high (no back-pressure; a valid every cycle is accepted).
// envelope_valid_out and echo_pulse_out are single-cycle strobes.
module echo_detector #(
    parameter int DATA_WIDTH    = sonar_pkg::DATA_WIDTH,
    parameter int TIME_WIDTH    = sonar_pkg::TIME_WIDTH,
    parameter int MIDSCALE      = sonar_pkg::MIDSCALE,
    parameter int AVG_LOG2      = 2,
    parameter int CONFIRM_COUNT = 3,
    parameter int BLANK_CYCLES  = 524288
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic [TIME_WIDTH-1:0] time_since_emission,
    input  logic [DATA_WIDTH-1:0] threshold_in,
    output logic [DATA_WIDTH-1:0] envelope_out,
    output logic                  envelope_valid_out,
    output logic                  echo_pulse_out,
    output logic                  echo_detected_out,
    output logic [TIME_WIDTH-1:0] echo_time_out,
    output logic [1:0]            dbg_state_o
);

    localparam int RUN_W = $clog2(CONFIRM_COUNT + 1);
    localparam logic [RUN_W-1:0]      RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0]      RUN_TARGET = RUN_W'(CONFIRM_COUNT);
    localparam logic [TIME_WIDTH-1:0] BLANK_TS   = TIME_WIDTH'(BLANK_CYCLES);

    logic [DATA_WIDTH-1:0] env;
    logic [TIME_WIDTH-1:0] ts2;
    logic                  env_valid;
    logic                  above;
    logic [RUN_W-1:0]      run_inc;

    sonar_pkg::det_state_t state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [TIME_WIDTH-1:0] cand_q, cand_d;
    logic [TIME_WIDTH-1:0] echo_time_q, echo_time_d;
    logic                  detected_q, detected_d;
    logic                  pulse_q, pulse_d;

    envelope_filter #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIME_WIDTH (TIME_WIDTH),
        .MIDSCALE   (MIDSCALE),
        .AVG_LOG2   (AVG_LOG2)
    ) u_filter (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .valid_i    (sample_valid_in),
        .sample_i   (sample_in),
        .ts_i       (time_since_emission),
        .envelope_o (env),
        .ts_o       (ts2),
        .valid_o    (env_valid)
    );

    // Equality with the threshold counts as below.
    assign above   = (env > threshold_in);
    assign run_inc = run_q + RUN_ONE;

    // Detection state register and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= sonar_pkg::ARMED;
            run_q       <= '0;
            cand_q      <= '0;
            echo_time_q <= '0;
            detected_q  <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            cand_q      <= cand_d;
            echo_time_q <= echo_time_d;
            detected_q  <= detected_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state logic: blanking only gates the start of a run, since the
    // timestamp is monotonic within a burst.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        cand_d      = cand_q;
        echo_time_d = echo_time_q;
        detected_d  = detected_q;
        pulse_d     = 1'b0;
        if (env_valid) begin
            unique case (state_q)
                sonar_pkg::ARMED: begin
                    if ((ts2 >= BLANK_TS) && above) begin
                        cand_d = ts2;
                        run_d  = RUN_ONE;
                        if (CONFIRM_COUNT == 1) begin
                            state_d     = sonar_pkg::DETECTED;
                            pulse_d     = 1'b1;
                            detected_d  = 1'b1;
                            echo_time_d = ts2;
                        end else begin
                            state_d = sonar_pkg::CONFIRM;
                        end
                    end
                end
                sonar_pkg::CONFIRM: begin
                    if (above) begin
                        run_d = run_inc;
                        if (run_inc == RUN_TARGET) begin
                            state_d     = sonar_pkg::DETECTED;
                            pulse_d     = 1'b1;
                            detected_d  = 1'b1;
                            echo_time_d = cand_q;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = sonar_pkg::ARMED;
                    end
                end
                sonar_pkg::DETECTED: begin
                    state_d = sonar_pkg::DETECTED;
                end
                default: begin
                    state_d = sonar_pkg::ARMED;
                end
            endcase
        end
    end

    assign envelope_out       = env;
    assign envelope_valid_out = env_valid;
    assign echo_pulse_out     = pulse_q;
    assign echo_detected_out  = detected_q;
    assign echo_time_out      = echo_time_q;
    assign dbg_state_o        = state_q;

endmodule

// File: doc/echo_detector.md
Name: echo_detector

Overview:
- Replaces the single-compare echo threshold between receive_beamformer and time_of_flight.
- Consumes the beamformed aggregate waveform (offset-binary, one sample per ADC data-valid strobe).
- Rectifies it and smooths it into an envelope.
- Suppresses transmitter ring-down with a blanking window and requires N consecutive above-threshold envelope samples.
- Emits a sticky echo flag plus the emission-relative timestamp of the first crossing sample.

Parameters:
- DATA_WIDTH, 16, width of sample_in and envelope.
- TIME_WIDTH, 24, width of time_since_emission.
- MIDSCALE, 32768, zero-signal code subtracted from each sample.
- AVG_LOG2, 2, moving-average length is 2^AVG_LOG2 samples.
- CONFIRM_COUNT, 3, consecutive envelope samples > threshold needed to declare an echo (>=1).
- BLANK_CYCLES, 524288, detection is ignored while time_since_emission < this value (burst length).

Ports:
- clk_in, input, 1, system clock (100 MHz).
- rst_in, input, 1, synchronous active-high reset; the top level drives it with sys_rst || burst_start.
- sample_in, input, DATA_WIDTH, aggregated waveform sample, unsigned offset-binary.
- sample_valid_in, input, 1, sample_in is valid this cycle.
- time_since_emission, input, TIME_WIDTH, free-running count since burst start.
- threshold_in, input, DATA_WIDTH, envelope threshold; strict greater-than compare.
- envelope_out, output, DATA_WIDTH, current smoothed magnitude.
- envelope_valid_out, output, 1, one-cycle strobe when envelope_out updates.
- echo_pulse_out, output, 1, one-cycle strobe on detection.
- echo_detected_out, output, 1, sticky detection level until reset.
- echo_time_out, output, TIME_WIDTH, timestamp of the first sample of the confirming run.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0. Sample buffer, running sum, run counter and timestamps are 0. FSM goes to ARMED.
- Stage 1 (cycle t+1 after a valid at t):
  - diff = sample_in - MIDSCALE as a signed DATA_WIDTH+1 value.
  - mag = |diff|, unsigned DATA_WIDTH; sample 0 gives mag 32768, which fits.
  - time_since_emission is registered alongside as ts1.
- Stage 2 (t+2):
  - Circular buffer of 2^AVG_LOG2 mags with a write pointer.
  - sum <= sum + mag - buf[wptr]; buf[wptr] <= mag; wptr wraps modulo 2^AVG_LOG2.
  - sum width is DATA_WIDTH+AVG_LOG2; no overflow is possible.
  - envelope_out <= sum_next >> AVG_LOG2; envelope_valid_out high for 1 cycle; ts2 <= ts1.
  - The buffer starts at zeros, so the envelope ramps up over the first 2^AVG_LOG2 samples. This is intended.
- Pipeline stalls are not needed: the stages advance only on valid and hold otherwise. Back-to-back valids every cycle are supported.
- FSM (evaluated on envelope_valid, cycle t+3 registered outputs):
  - ARMED:
    - If ts2 < BLANK_CYCLES, stay.
    - Else if envelope > threshold_in: cand_time <= ts2 and run <= 1. If CONFIRM_COUNT == 1, go DETECTED directly; otherwise go CONFIRM.
  - CONFIRM:
    - If envelope > threshold_in: run++. When run reaches CONFIRM_COUNT, go DETECTED.
    - Else: run <= 0, go ARMED.
    - The blanking check does not apply once in CONFIRM, since ts is monotonic within a period.
  - Entering DETECTED: echo_pulse_out = 1 for exactly one cycle, echo_detected_out <= 1, echo_time_out <= cand_time.
  - DETECTED: absorbing until rst_in; envelope outputs continue updating. Only the first echo per burst is reported.
- Threshold equality does not count (envelope == threshold is "below").
- Reset mid-operation (in CONFIRM or mid-pipeline): in-flight samples are discarded, the buffer is cleared, and no pulse is produced.
- Latency: sample valid at t → envelope at t+2 → echo_pulse at t+3 (for the confirming sample).

Decomposition:
- sonar_pkg holds:
  - DATA_WIDTH, TIME_WIDTH and MIDSCALE constants (shared with spi_con, receive_beamformer and time_of_flight).
  - The det_state_t enum {ARMED, CONFIRM, DETECTED}.
- Sub-module envelope_filter implements stages 1–2, with ports: valid in, sample, ts in; envelope, ts, valid out.
- The FSM, blanking and timestamp logic stay in echo_detector.

Test Plan:
- Reset check: assert rst_in for 2 cycles → every output is 0. The next valid sample of 32768 gives envelope_out = 0 at t+2.
- Rectification:
  - Samples 40768, 24768, 40768, 24768 → envelope 2000, 4000, 6000, 8000.
  - A single sample of 0 after reset → envelope 8192.
- Detection, threshold 5000, time > 524288:
  - Stimulus: constant 40768 with time 600000, 600001, 600002, …
  - Envelope exceeds 5000 on sample 3; confirmed on sample 5.
  - Expected: echo_pulse 1 cycle, echo_detected = 1, echo_time_out = 600002.
- Blanking: the same stimulus with time 100000.. → no pulse and echo_detected stays 0. The envelope still updates.
- Broken run: envelope sequence 6000, 6000, 4000, 6000, 6000, 6000 → the run resets at 4000. The pulse occurs on the last 6000, with echo_time = timestamp of the 4th sample.
- Equality and reset:
  - Envelope == 5000 for 10 samples → no detection.
  - rst_in asserted in CONFIRM at run = 2 → no pulse, outputs are 0 the next cycle.
